// File: rtl/i2c_eeprom_ctrl_if.sv
// Byte-event and ROM-port bundle between the I2C slave byte engine and the EEPROM protocol layer.
// The slave modport is the protocol layer; the master modport is the byte engine plus ROM.
interface i2c_eeprom_ctrl_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  logic              in_start;
  logic              in_stop;
  logic              in_sel;
  logic              in_rw;
  logic              in_rx_valid;
  logic [DATA_W-1:0] in_rx_data;
  logic              out_rx_ack;
  logic              in_tx_req;
  logic              out_tx_valid;
  logic [DATA_W-1:0] out_tx_data;
  logic              out_mem_rd_en;
  logic [ADDR_W-1:0] out_mem_addr;
  logic [DATA_W-1:0] in_mem_rdata;
  logic [ADDR_W-1:0] out_ptr;

  modport slave (
    input  in_start, in_stop, in_sel, in_rw, in_rx_valid, in_rx_data, in_tx_req, in_mem_rdata,
    output out_rx_ack, out_tx_valid, out_tx_data, out_mem_rd_en, out_mem_addr, out_ptr
  );

  modport master (
    output in_start, in_stop, in_sel, in_rw, in_rx_valid, in_rx_data, in_tx_req, in_mem_rdata,
    input  out_rx_ack, out_tx_valid, out_tx_data, out_mem_rd_en, out_mem_addr, out_ptr
  );
endinterface

// File: rtl/i2c_eeprom_ctrl.sv
// 24Cxx-style protocol layer: a write loads the word pointer (hi, lo), reads stream ROM bytes
// from the pointer with auto-increment, so a later read continues at the current address.
module i2c_eeprom_ctrl #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic                 in_ext_osc,
  input  logic                 in_reset_n,
  i2c_eeprom_ctrl_if.slave     bus
);

  typedef enum logic [2:0] {StIdle, StAddrHi, StAddrLo, StWrData, StRead, StFetch} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                rd_en_q, rd_en_d;
  logic                tx_valid_q, tx_valid_d;
  logic                ack_q, ack_d;
  logic [2*DATA_W-1:0] full_addr;
  logic                abort;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    addr_d     = addr_q;
    hi_d       = hi_q;
    rd_en_d    = 1'b0;
    tx_valid_d = 1'b0;
    full_addr  = {hi_q, bus.in_rx_data};
    abort      = bus.in_start | bus.in_stop | bus.in_sel;
    // ROM data arrives in the tx_valid cycle; latch it there so it holds until the next pulse.
    tx_data_d  = tx_valid_q ? bus.in_mem_rdata : tx_data_q;

    case (state_q)
      StAddrHi: begin
        if (bus.in_rx_valid) begin
          hi_d    = bus.in_rx_data;
          state_d = StAddrLo;
        end
      end
      StAddrLo: begin
        if (bus.in_rx_valid) begin
          ptr_d   = full_addr[ADDR_W-1:0];
          state_d = StWrData;
        end
      end
      StRead: begin
        // A request coinciding with a bus event would never be delivered, so drop it.
        if (bus.in_tx_req && !abort) begin
          rd_en_d = 1'b1;
          addr_d  = ptr_q;
          ptr_d   = ptr_q + ADDR_W'(1);
          state_d = StFetch;
        end
      end
      StFetch: begin
        tx_valid_d = 1'b1;
        state_d    = StRead;
      end
      default: ;
    endcase

    if (bus.in_stop || bus.in_start) state_d = StIdle;
    if (bus.in_sel) state_d = bus.in_rw ? StRead : StAddrHi;

    ack_d = (state_d == StAddrHi) || (state_d == StAddrLo);
  end

  always_ff @(posedge in_ext_osc or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      addr_q     <= '0;
      hi_q       <= '0;
      tx_data_q  <= '0;
      rd_en_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      addr_q     <= addr_d;
      hi_q       <= hi_d;
      tx_data_q  <= tx_data_d;
      rd_en_q    <= rd_en_d;
      tx_valid_q <= tx_valid_d;
      ack_q      <= ack_d;
    end
  end

  assign bus.out_rx_ack    = ack_q;
  assign bus.out_tx_valid  = tx_valid_q;
  assign bus.out_tx_data   = tx_valid_q ? bus.in_mem_rdata : tx_data_q;
  assign bus.out_mem_rd_en = rd_en_q;
  assign bus.out_mem_addr  = addr_q;
  assign bus.out_ptr       = ptr_q;

endmodule

// File: tb/tb_i2c_eeprom_ctrl.sv
// Bench for i2c_eeprom_ctrl with a 12-bit pointer, a synchronous ROM model and a scoreboard
// that checks every ROM access and every delivered read byte, including their latency.
module tb_i2c_eeprom_ctrl;
  localparam int unsigned AW = 12;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    rom_q;
  logic [AW-1:0] exp_ptr;
  int            vectors = 0;
  int            errors = 0;
  int            cyc = 0;
  exp_t          rd_q[$];
  exp_t          tx_q[$];

  always #5 clk = ~clk;

  i2c_eeprom_ctrl_if #(.ADDR_W(AW), .DATA_W(8)) bus ();

  i2c_eeprom_ctrl #(.ADDR_W(AW), .DATA_W(8)) dut (
    .in_ext_osc (clk),
    .in_reset_n (rst_n),
    .bus        (bus)
  );

  function automatic logic [7:0] rom_byte(input logic [AW-1:0] a);
    logic [15:0] x;
    x = 16'(a);
    return 8'(x * 16'd7 + 16'd3) ^ x[11:4];
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.out_mem_rd_en) rom_q <= rom_byte(bus.out_mem_addr);
  end
  assign bus.in_mem_rdata = rom_q;

  // Scoreboard: ROM strobe one cycle after the request, byte delivery two cycles after.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_mem_rd_en) begin
        vectors++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected: rd_en with addr %h, required no access", bus.out_mem_addr);
        end else begin
          exp_t e;
          e = rd_q.pop_front();
          if (bus.out_mem_addr !== e.addr || cyc !== e.cyc + 1) begin
            errors++;
            $display("FAIL rd_addr: addr %h at +%0d, required %h at +1", bus.out_mem_addr,
                     cyc - e.cyc, e.addr);
          end
        end
      end
      if (bus.out_tx_valid) begin
        vectors++;
        if (tx_q.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected: tx_valid with data %h, required none", bus.out_tx_data);
        end else begin
          exp_t e;
          e = tx_q.pop_front();
          if (bus.out_tx_data !== e.data || cyc !== e.cyc + 2) begin
            errors++;
            $display("FAIL tx_data: data %h at +%0d, required %h at +2 (addr %h)",
                     bus.out_tx_data, cyc - e.cyc, e.data, e.addr);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_sel(input logic rw);
    bus.in_sel = 1'b1;
    bus.in_rw  = rw;
    step(1);
    bus.in_sel = 1'b0;
    step(1);
  endtask

  task automatic pulse_stop();
    bus.in_stop = 1'b1;
    step(1);
    bus.in_stop = 1'b0;
    step(1);
  endtask

  task automatic pulse_start();
    bus.in_start = 1'b1;
    step(1);
    bus.in_start = 1'b0;
    step(1);
  endtask

  task automatic write_byte(input logic [7:0] d);
    bus.in_rx_valid = 1'b1;
    bus.in_rx_data  = d;
    step(1);
    bus.in_rx_valid = 1'b0;
    step(1);
  endtask

  // Issue one read request and record what the ROM access and delivered byte must be.
  task automatic read_req(input int gap);
    exp_t e;
    e.addr = exp_ptr;
    e.data = rom_byte(exp_ptr);
    e.cyc  = cyc;
    rd_q.push_back(e);
    tx_q.push_back(e);
    exp_ptr = exp_ptr + AW'(1);
    bus.in_tx_req = 1'b1;
    step(1);
    bus.in_tx_req = 1'b0;
    step(gap);
  endtask

  task automatic set_ptr(input logic [7:0] hi, input logic [7:0] lo);
    pulse_sel(1'b0);
    write_byte(hi);
    write_byte(lo);
    pulse_stop();
    exp_ptr = AW'({hi, lo});
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && tx_q.size() != 0; i++) step(1);
    vectors++;
    if (tx_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d bytes outstanding, required 0", tx_q.size());
      tx_q.delete();
      rd_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    {bus.in_start, bus.in_stop, bus.in_sel, bus.in_rw, bus.in_rx_valid, bus.in_tx_req} = '0;
    bus.in_rx_data = '0;
    #2 rst_n = 1'b0;
    #10;
    vectors++;
    if ({bus.out_ptr, bus.out_mem_addr, bus.out_tx_data} !== '0 ||
        {bus.out_rx_ack, bus.out_mem_rd_en, bus.out_tx_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs: ptr %h addr %h data %h ack/rd/tv %b, required all zero",
               bus.out_ptr, bus.out_mem_addr, bus.out_tx_data,
               {bus.out_rx_ack, bus.out_mem_rd_en, bus.out_tx_valid});
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    exp_ptr = '0;
    // Requests and bytes while idle must not touch memory or the pointer.
    bus.in_tx_req = 1'b1;
    step(1);
    bus.in_tx_req = 1'b0;
    write_byte(8'h77);
    step(3);
    vectors++;
    if (bus.out_ptr !== exp_ptr || bus.out_rx_ack !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: ptr %h ack %b, required %h 0", bus.out_ptr,
               bus.out_rx_ack, exp_ptr);
    end
  endtask

  task automatic test_write_read();
    pulse_sel(1'b0);
    vectors++;
    if (bus.out_rx_ack !== 1'b1) begin
      errors++;
      $display("FAIL ack_after_sel: ack %b, required 1", bus.out_rx_ack);
    end
    write_byte(8'h00);
    write_byte(8'h01);
    exp_ptr = 12'h001;
    vectors++;
    if (bus.out_ptr !== exp_ptr || bus.out_rx_ack !== 1'b0) begin
      errors++;
      $display("FAIL addr_commit: ptr %h ack %b, required %h 0", bus.out_ptr, bus.out_rx_ack,
               exp_ptr);
    end
    pulse_sel(1'b1);
    for (int i = 0; i < 4; i++) read_req(3);
    drain();
    pulse_stop();
    vectors++;
    if (bus.out_ptr !== 12'h005) begin
      errors++;
      $display("FAIL ptr_after_read: ptr %h, required 005", bus.out_ptr);
    end
  endtask

  task automatic test_truncate();
    set_ptr(8'hAA, 8'hCC);
    vectors++;
    if (bus.out_ptr !== 12'hACC) begin
      errors++;
      $display("FAIL truncate: ptr %h, required ACC", bus.out_ptr);
    end
    pulse_sel(1'b1);
    for (int i = 0; i < 8; i++) read_req(3);
    drain();
    pulse_stop();
    vectors++;
    if (bus.out_ptr !== 12'hAD4) begin
      errors++;
      $display("FAIL truncate_stream: ptr %h, required AD4", bus.out_ptr);
    end
  endtask

  task automatic test_wrap();
    set_ptr(8'h0F, 8'hFE);
    pulse_sel(1'b1);
    for (int i = 0; i < 3; i++) read_req(3);
    drain();
    pulse_stop();
    vectors++;
    if (bus.out_ptr !== 12'h001) begin
      errors++;
      $display("FAIL wrap: ptr %h, required 001", bus.out_ptr);
    end
  endtask

  task automatic test_abort();
    pulse_sel(1'b0);
    write_byte(8'h12);
    pulse_stop();
    vectors++;
    if (bus.out_ptr !== 12'h001 || bus.out_rx_ack !== 1'b0) begin
      errors++;
      $display("FAIL stop_after_hi: ptr %h ack %b, required 001 0", bus.out_ptr, bus.out_rx_ack);
    end
    pulse_sel(1'b0);
    write_byte(8'h34);
    pulse_start();
    vectors++;
    if (bus.out_ptr !== 12'h001) begin
      errors++;
      $display("FAIL start_after_hi: ptr %h, required 001", bus.out_ptr);
    end
    pulse_sel(1'b0);
    write_byte(8'h00);
    write_byte(8'h07);
    write_byte(8'h55);
    vectors++;
    if (bus.out_ptr !== 12'h007 || bus.out_rx_ack !== 1'b0) begin
      errors++;
      $display("FAIL data_nack: ptr %h ack %b, required 007 0", bus.out_ptr, bus.out_rx_ack);
    end
    pulse_stop();
    // Low byte and STOP in the same cycle still commit the pointer.
    pulse_sel(1'b0);
    write_byte(8'h00);
    bus.in_rx_valid = 1'b1;
    bus.in_rx_data  = 8'h20;
    bus.in_stop     = 1'b1;
    step(1);
    bus.in_rx_valid = 1'b0;
    bus.in_stop     = 1'b0;
    step(1);
    exp_ptr = 12'h020;
    vectors++;
    if (bus.out_ptr !== exp_ptr || bus.out_rx_ack !== 1'b0) begin
      errors++;
      $display("FAIL rx_with_stop: ptr %h ack %b, required 020 0", bus.out_ptr, bus.out_rx_ack);
    end
    // STOP during the fetch cycle: byte still delivered, increment kept, then idle.
    pulse_sel(1'b1);
    read_req(0);
    bus.in_stop = 1'b1;
    step(1);
    bus.in_stop = 1'b0;
    drain();
    bus.in_tx_req = 1'b1;
    step(1);
    bus.in_tx_req = 1'b0;
    step(3);
    vectors++;
    if (bus.out_ptr !== 12'h021) begin
      errors++;
      $display("FAIL stop_in_fetch: ptr %h, required 021", bus.out_ptr);
    end
  endtask

  task automatic test_back_to_back();
    set_ptr(8'h01, 8'h00);
    pulse_sel(1'b1);
    for (int i = 0; i < 4; i++) read_req(1);
    drain();
    pulse_stop();
    vectors++;
    if (bus.out_ptr !== 12'h104) begin
      errors++;
      $display("FAIL back_to_back: ptr %h, required 104", bus.out_ptr);
    end
  endtask

  task automatic test_current_addr();
    set_ptr(8'h00, 8'h01);
    pulse_sel(1'b1);
    for (int i = 0; i < 4; i++) read_req(3);
    drain();
    pulse_stop();
    pulse_sel(1'b1);
    for (int i = 0; i < 2; i++) read_req(3);
    drain();
    vectors++;
    if (bus.out_ptr !== 12'h007) begin
      errors++;
      $display("FAIL current_addr: ptr %h, required 007", bus.out_ptr);
    end
    // Reset while the fetch is in flight: the byte must never be delivered.
    read_req(0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (tx_q.size() != 1 || bus.out_tx_valid !== 1'b0 || bus.out_ptr !== 12'h000) begin
      errors++;
      $display("FAIL reset_in_fetch: pending %0d tv %b ptr %h, required 1 0 000", tx_q.size(),
               bus.out_tx_valid, bus.out_ptr);
    end
    tx_q.delete();
    rd_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_truncate();
    test_wrap();
    test_abort();
    test_back_to_back();
    test_current_addr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
